rgb_led_sequencer: RTL and testbench

Parametrised successor to the board-level RGB LED counter. It drives `NUM_LEDS` RGB LEDs from a 3·`NUM_LEDS`-bit sequence counter that advances on an internal prescaled tick. It supports up, down and bounce counting, hold, synchronous clear and global PWM brightness dimming. It sits directly under the board top level, fed by switches/buttons, with its `led_*` outputs wired to the board RGB pins.

---
 rtl/rgb_led_sequencer_if.sv | 42 ++++
 rtl/rgb_led_sequencer.sv | 140 ++++++++++++++
 tb/tb_rgb_led_sequencer.sv | 192 +++++++++++++++++++
 3 files changed

// File: rtl/rgb_led_sequencer_if.sv
// rgb_led_sequencer_if: control and LED bundle of the RGB LED sequencer.
// master drives enable/clear/mode/brightness; slave drives count/wrap/led_*.
interface rgb_led_sequencer_if #(
  parameter int NUM_LEDS = 4,
  parameter int PWM_BITS = 4
);
  localparam int W = 3 * NUM_LEDS;

  logic                enable;
  logic                clear;
  logic [1:0]          mode;
  logic [PWM_BITS-1:0] brightness;
  logic [W-1:0]        count;
  logic                wrap;
  logic [NUM_LEDS-1:0] led_r;
  logic [NUM_LEDS-1:0] led_g;
  logic [NUM_LEDS-1:0] led_b;

  modport master (
    output enable,
    output clear,
    output mode,
    output brightness,
    input  count,
    input  wrap,
    input  led_r,
    input  led_g,
    input  led_b
  );

  modport slave (
    input  enable,
    input  clear,
    input  mode,
    input  brightness,
    output count,
    output wrap,
    output led_r,
    output led_g,
    output led_b
  );
endinterface

// File: rtl/rgb_led_sequencer.sv
// rgb_led_sequencer: prescaled up/down/bounce counter shown on RGB LEDs.
// Ports: clk, reset (async, active-low), bus (slave: controls in, count/wrap/leds out).
module rgb_led_sequencer #(
  parameter int NUM_LEDS = 4,
  parameter int PRESCALE = 25_000_000,
  parameter int PWM_BITS = 4
) (
  input  logic               clk,
  input  logic               reset,
  rgb_led_sequencer_if.slave bus
);
  localparam int W  = 3 * NUM_LEDS;
  localparam int PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [PW-1:0] PRESC_MAX = PW'(PRESCALE - 1);
  localparam logic [W-1:0]  CNT_MAX   = '1;

  typedef enum logic {
    DIR_UP = 1'b0,
    DIR_DN = 1'b1
  } dir_e;

  logic [PW-1:0]       presc_q, presc_d;
  logic                tick;
  logic [W-1:0]        count_q, count_d;
  logic                wrap_q, wrap_d;
  dir_e                dir_q, dir_d;
  logic [PWM_BITS-1:0] pwm_cnt_q, pwm_cnt_d;
  logic                pwm_on;
  logic [NUM_LEDS-1:0] led_r_q, led_r_d;
  logic [NUM_LEDS-1:0] led_g_q, led_g_d;
  logic [NUM_LEDS-1:0] led_b_q, led_b_d;

  always_comb begin
    tick    = 1'b0;
    presc_d = presc_q + PW'(1);
    if (bus.clear || !bus.enable) begin
      presc_d = '0;
    end else if (presc_q == PRESC_MAX) begin
      presc_d = '0;
      tick    = 1'b1;
    end
  end

  always_comb begin
    count_d = count_q;
    wrap_d  = 1'b0;
    dir_d   = dir_q;
    // outside bounce the direction is parked at up
    if (bus.mode != 2'b11) dir_d = DIR_UP;
    if (bus.clear) begin
      count_d = '0;
      dir_d   = DIR_UP;
    end else if (tick) begin
      unique case (bus.mode)
        2'b01: begin
          if (count_q == CNT_MAX) begin
            count_d = '0;
            wrap_d  = 1'b1;
          end else begin
            count_d = count_q + W'(1);
          end
        end
        2'b10: begin
          if (count_q == '0) begin
            count_d = CNT_MAX;
            wrap_d  = 1'b1;
          end else begin
            count_d = count_q - W'(1);
          end
        end
        2'b11: begin
          if (dir_q == DIR_UP) begin
            if (count_q == CNT_MAX) begin
              count_d = CNT_MAX - W'(1);
              dir_d   = DIR_DN;
              wrap_d  = 1'b1;
            end else begin
              count_d = count_q + W'(1);
            end
          end else begin
            if (count_q == '0) begin
              count_d = W'(1);
              dir_d   = DIR_UP;
              wrap_d  = 1'b1;
            end else begin
              count_d = count_q - W'(1);
            end
          end
        end
        default: begin
        end
      endcase
    end
  end

  always_comb begin
    pwm_cnt_d = pwm_cnt_q + PWM_BITS'(1);
    // all-ones brightness must be fully on, not 15/16
    pwm_on    = (&bus.brightness) || (pwm_cnt_q < bus.brightness);
  end

  always_comb begin
    led_r_d = '0;
    led_g_d = '0;
    led_b_d = '0;
    for (int i = 0; i < NUM_LEDS; i++) begin
      led_r_d[i] = count_q[3*i+2] & pwm_on;
      led_g_d[i] = count_q[3*i+1] & pwm_on;
      led_b_d[i] = count_q[3*i]   & pwm_on;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      presc_q   <= '0;
      count_q   <= '0;
      wrap_q    <= 1'b0;
      dir_q     <= DIR_UP;
      pwm_cnt_q <= '0;
      led_r_q   <= '0;
      led_g_q   <= '0;
      led_b_q   <= '0;
    end else begin
      presc_q   <= presc_d;
      count_q   <= count_d;
      wrap_q    <= wrap_d;
      dir_q     <= dir_d;
      pwm_cnt_q <= pwm_cnt_d;
      led_r_q   <= led_r_d;
      led_g_q   <= led_g_d;
      led_b_q   <= led_b_d;
    end
  end

  assign bus.count = count_q;
  assign bus.wrap  = wrap_q;
  assign bus.led_r = led_r_q;
  assign bus.led_g = led_g_q;
  assign bus.led_b = led_b_q;
endmodule

// File: tb/tb_rgb_led_sequencer.sv
// tb_rgb_led_sequencer: directed checks of rgb_led_sequencer.
// NUM_LEDS=2 (W=6, M=63), PRESCALE=4, PWM_BITS=4.
module tb_rgb_led_sequencer;
  logic clk;
  logic reset;

  int n_checks = 0;
  int n_errors = 0;

  rgb_led_sequencer_if #(.NUM_LEDS(2), .PWM_BITS(4)) bus ();

  rgb_led_sequencer #(
    .NUM_LEDS(2),
    .PRESCALE(4),
    .PWM_BITS(4)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic clks(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  function automatic logic [31:0] leds();
    return 32'({bus.led_r, bus.led_g, bus.led_b});
  endfunction

  initial begin
    #200000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1, "timeout");
  end

  initial begin
    int on_cnt;
    int moves;
    int wraps;
    logic [3:0] bvec [4];
    int         evec [4];
    bvec = '{4'd0, 4'd5, 4'd8, 4'd15};
    evec = '{0, 5, 8, 16};

    reset = 1'b0;
    bus.enable = 1'b0;
    bus.clear = 1'b0;
    bus.mode = 2'b00;
    bus.brightness = 4'd0;
    clks(2);
    check("rst_count", 32'(bus.count), 0);
    check("rst_wrap", 32'(bus.wrap), 0);
    check("rst_leds", leds(), 0);

    bus.enable = 1'b1;
    bus.mode = 2'b01;
    bus.brightness = 4'hF;
    reset = 1'b1;
    clks(3);
    check("first_pre", 32'(bus.count), 0);
    clks(1);
    check("first_step", 32'(bus.count), 1);
    clks(4 * 36);
    check("count37", 32'(bus.count), 37);
    clks(1);
    check("led_r37", 32'(bus.led_r), 3);
    check("led_g37", 32'(bus.led_g), 0);
    check("led_b37", 32'(bus.led_b), 1);

    #2 reset = 1'b0;
    #1;
    check("async_count", 32'(bus.count), 0);
    check("async_wrap", 32'(bus.wrap), 0);
    check("async_leds", leds(), 0);
    clks(1);
    reset = 1'b1;
    clks(3);
    check("rel_pre", 32'(bus.count), 0);
    clks(1);
    check("rel_step", 32'(bus.count), 1);

    clks(4 * 61);
    check("up62", 32'(bus.count), 62);
    clks(4);
    check("up63", 32'(bus.count), 63);
    check("up63_wrap", 32'(bus.wrap), 0);
    clks(1);
    check("led_r1_63", 32'(bus.led_r[1]), 1);
    clks(3);
    check("up_wrap0", 32'(bus.count), 0);
    check("up_wrap", 32'(bus.wrap), 1);
    clks(1);
    check("up_wrap_end", 32'(bus.wrap), 0);
    check("led_r1_0", 32'(bus.led_r[1]), 0);

    bus.mode = 2'b10;
    clks(3);
    check("dn_wrap63", 32'(bus.count), 63);
    check("dn_wrap", 32'(bus.wrap), 1);
    clks(4);
    check("dn62", 32'(bus.count), 62);

    bus.mode = 2'b11;
    clks(4);
    check("bn63", 32'(bus.count), 63);
    check("bn63_wrap", 32'(bus.wrap), 0);
    clks(4);
    check("bn_turn62", 32'(bus.count), 62);
    check("bn_turn_wrap", 32'(bus.wrap), 1);
    clks(4);
    check("bn61", 32'(bus.count), 61);
    bus.mode = 2'b01;
    clks(1);
    bus.mode = 2'b11;
    clks(3);
    check("bn_resume_up", 32'(bus.count), 62);
    clks(4 * 64);
    check("bn_bottom0", 32'(bus.count), 0);
    check("bn_bottom_wrap", 32'(bus.wrap), 0);
    clks(4);
    check("bn_turn1", 32'(bus.count), 1);
    check("bn_turn1_wrap", 32'(bus.wrap), 1);
    clks(4);
    check("bn2", 32'(bus.count), 2);

    bus.mode = 2'b10;
    clks(12);
    check("to63", 32'(bus.count), 63);
    bus.mode = 2'b01;
    clks(3);
    bus.clear = 1'b1;
    clks(1);
    check("clr_count", 32'(bus.count), 0);
    check("clr_wrap", 32'(bus.wrap), 0);
    bus.clear = 1'b0;
    clks(4);
    check("clr_next", 32'(bus.count), 1);

    clks(2);
    bus.enable = 1'b0;
    clks(1);
    bus.enable = 1'b1;
    clks(3);
    check("en_hold", 32'(bus.count), 1);
    clks(1);
    check("en_step", 32'(bus.count), 2);

    bus.mode = 2'b10;
    clks(12);
    check("hold_start", 32'(bus.count), 63);
    bus.mode = 2'b00;
    moves = 0;
    wraps = 0;
    for (int i = 0; i < 100; i++) begin
      clks(1);
      if (bus.count != 6'd63) moves++;
      if (bus.wrap) wraps++;
    end
    check("hold_moves", 32'(moves), 0);
    check("hold_wraps", 32'(wraps), 0);

    for (int k = 0; k < 4; k++) begin
      bus.brightness = bvec[k];
      clks(1);
      on_cnt = 0;
      for (int i = 0; i < 16; i++) begin
        clks(1);
        if (&{bus.led_r, bus.led_g, bus.led_b}) on_cnt++;
      end
      check($sformatf("pwm_b%0d", bvec[k]), 32'(on_cnt), 32'(evec[k]));
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
